alu_divmod_seq: RTL and testbench

Multi-cycle unsigned divider/modulo unit for the ALU datapath. It sits directly upstream of the single-step conditional-subtract stage and drives it once per cycle: it shifts the partial remainder, presents it with the divisor, and captures the reduced result. After WIDTH iterations it produces quotient and remainder together. A start/busy/done handshake lets the ALU control sequencer issue one operation at a time.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/cond_sub_step.sv | 29 ++
 rtl/alu_divmod_seq.sv | 133 +++++++++++++
 tb/tb_alu_divmod_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU datapath blocks.
//                Holds the divider/modulo FSM state type and its default
//                operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Divider/modulo sequencer states. The encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divmod_state_t;

    localparam int DIVMOD_DEFAULT_WIDTH = 8;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/cond_sub_step.sv
`default_nettype none
// ============================================================================
//  Module      : cond_sub_step
//  Description : One restoring-division step. Subtracts div from t when
//                t >= div and reports whether the subtraction happened.
//                Purely combinational.
//  Ports       : t      in  WIDTH  shifted partial remainder
//                div    in  WIDTH  divisor, zero-extended by the caller
//                result out WIDTH  t - div when q_bit is set, otherwise t
//                q_bit  out 1      quotient bit, (t >= div)
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_sub_step #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] result,
    output logic             q_bit
);

    logic w_ge;

    assign w_ge   = (t >= div);
    assign q_bit  = w_ge;
    assign result = w_ge ? (t - div) : t;

endmodule : cond_sub_step
`default_nettype wire

// File: rtl/alu_divmod_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_divmod_seq
//  Description : Multi-cycle unsigned divider/modulo unit. Runs one
//                restoring-division step per cycle through cond_sub_step
//                and delivers quotient and remainder together after WIDTH
//                iterations. A zero divisor finishes in a single cycle with
//                a saturated quotient.
//  Ports       : clk         in  1      system clock, rising edge
//                rst         in  1      asynchronous active-high reset
//                start       in  1      request an operation (IDLE only)
//                dividend    in  WIDTH  numerator, captured on accept
//                divisor     in  WIDTH  denominator, captured on accept
//                busy        out 1      high while CALC or DONE
//                done        out 1      one-cycle result-valid pulse
//                quotient    out WIDTH  floor(dividend / divisor)
//                remainder   out WIDTH  dividend mod divisor
//                div_by_zero out 1      divisor was zero, held with results
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_divmod_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIVMOD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);

    divmod_state_t      r_state;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH:0]     w_t;
    logic [WIDTH:0]     w_result;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_unused;

    // Shift the next dividend bit (MSB of the quotient register, which
    // still holds unconsumed dividend bits) into the partial remainder.
    assign w_t        = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

    // After a step the remainder is below the divisor, so the top bit of
    // both the stored and the freshly reduced remainder is always zero.
    assign w_unused   = ^{r_rem[WIDTH], w_result[WIDTH]};

    cond_sub_step #(
        .WIDTH (WIDTH + 1)
    ) u_step (
        .t      (w_t),
        .div    ({1'b0, r_div}),
        .result (w_result),
        .q_bit  (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_div       <= divisor;
                        r_quo       <= dividend;
                        r_rem       <= '0;
                        r_cnt       <= c_CNT_INIT;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        if (divisor == '0) begin
                            // Zero divisor short-circuits straight to DONE.
                            r_state     <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end

                CALC: begin
                    r_rem <= w_result;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state   <= DONE;
                        done      <= 1'b1;
                        quotient  <= w_quo_next;
                        remainder <= w_result[WIDTH-1:0];
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : alu_divmod_seq
`default_nettype wire

// File: tb/tb_alu_divmod_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_divmod_seq
//  Description : Directed self-checking bench for alu_divmod_seq at
//                WIDTH=8, with a WIDTH=16 instance for spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_divmod_seq;

    int total = 0;
    int bad   = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [7:0]  dividend = '0;
    logic [7:0]  divisor  = '0;
    logic        busy, done, div_by_zero;
    logic [7:0]  quotient, remainder;

    logic        start16 = 1'b0;
    logic [15:0] dividend16 = '0;
    logic [15:0] divisor16  = '0;
    logic        busy16, done16, dz16;
    logic [15:0] quotient16, remainder16;

    always #5 clk = ~clk;

    alu_divmod_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    alu_divmod_seq #(.WIDTH(16)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .dividend    (dividend16),
        .divisor     (divisor16),
        .busy        (busy16),
        .done        (done16),
        .quotient    (quotient16),
        .remainder   (remainder16),
        .div_by_zero (dz16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=8 operation and check latency, busy span, results,
    // and the quiet cycle that follows.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int          n;
        int          busy_cnt;
        int          lat;
        logic [7:0]  eq, er;
        logic        ez;
        ez  = (b == 8'd0);
        eq  = ez ? 8'hFF : a / b;
        er  = ez ? a : a % b;
        lat = ez ? 1 : 9;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = ~a;
        divisor  = b + 8'd1;
        n        = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 30) begin
            tick();
            n++;
            if (busy) busy_cnt++;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " latency"}, n, lat);
        chk({tag, " busy_cycles"}, busy_cnt, lat);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, div_by_zero, ez);
        tick();
        chk({tag, " done_after"}, done, 0);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " quotient_held"}, quotient, eq);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input string tag);
        int n;
        dividend16 = a;
        divisor16  = b;
        start16    = 1'b1;
        tick();
        start16    = 1'b0;
        n = 1;
        while (!done16 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " done"}, done16, 1);
        chk({tag, " latency"}, n, 17);
        chk({tag, " quotient"}, quotient16, eq);
        chk({tag, " remainder"}, remainder16, er);
        chk({tag, " div_by_zero"}, dz16, 0);
        tick();
    endtask

    initial begin
        int n;
        int done_seen;

        // Reset state
        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst quotient", quotient, 0);
        chk("rst remainder", remainder, 0);
        chk("rst div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        tick();

        // Directed operations
        op8(8'd200, 8'd7,  "200/7");
        op8(8'd255, 8'd1,  "255/1");
        op8(8'd5,   8'd9,  "5/9");
        op8(8'd13,  8'd0,  "13/0");
        op8(8'd13,  8'd3,  "13/3");
        op8(8'd0,   8'd5,  "0/5");
        op8(8'd255, 8'd255,"255/255");

        // start held through a busy operation with changed operands
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        dividend = 8'd100;
        divisor  = 8'd10;
        n = 1;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk("held first latency", n, 9);
        chk("held first quotient", quotient, 28);
        chk("held first remainder", remainder, 4);
        tick();
        chk("held gap busy", busy, 0);
        tick();
        chk("held accept busy", busy, 1);
        start = 1'b0;
        n = 1;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk("held second latency", n, 9);
        chk("held second quotient", quotient, 10);
        chk("held second remainder", remainder, 0);
        tick();

        // Asynchronous reset in the middle of CALC
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst quotient", quotient, 0);
        chk("midrst remainder", remainder, 0);
        chk("midrst div_by_zero", div_by_zero, 0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("midrst no_done", done_seen, 0);
        op8(8'd200, 8'd7, "post_rst 200/7");

        // Random sweep against a division reference
        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");
        end

        // WIDTH=16 spot checks
        op16(16'd65535, 16'd255, 16'd257, 16'd0, "w16 65535/255");
        op16(16'd60000, 16'd7,   16'd8571, 16'd3, "w16 60000/7");
        op16(16'd1234,  16'd4321, 16'd0, 16'd1234, "w16 1234/4321");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_divmod_seq
`default_nettype wire
